// File: rtl/udp_app_pkg.sv
// rtl/udp_app_pkg.sv - Shared state encodings and word indices for udp_app_buf
package udp_app_pkg;

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_WAITLO = 2'd1,
        T_WAITHI = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_HOLD = 2'd1,
        R_WAIT = 2'd2
    } rx_state_t;

    localparam int UDP_HDR_LEN = 8;

    localparam int TXW_DST_IP  = 0;
    localparam int TXW_PORTS   = 1;
    localparam int TXW_LEN     = 2;
    localparam int RXW_LEN     = 1;
    localparam int RXW_PAYLOAD = 2;

endpackage

// File: rtl/udp_app_tx_bank.sv
// rtl/udp_app_tx_bank.sv - Ping-pong TX message store, one write port, one async read port
module udp_app_tx_bank #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [2][2**AW];

    // App writes land in the selected bank; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/udp_app_buf.sv
// rtl/udp_app_buf.sv - App-side manager for the UDP TX/RX buffer handshake
module udp_app_buf
    import udp_app_pkg::*;
#(
    parameter int AW       = 6,
    parameter int PERIOD_W = 28,
    parameter bit AUTO_REL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                udp_txbuf_grant,
    output logic                udp_txbuf_rel,
    input  logic [AW-1:0]       udp_txbuf_addr,
    input  logic                udp_txbuf_ce,
    output logic [31:0]         udp_txbuf_rdata,
    input  logic                udp_rxbuf_grant,
    output logic                udp_rxbuf_rel,
    input  logic [AW-1:0]       udp_rxbuf_addr,
    input  logic                udp_rxbuf_ce,
    input  logic                udp_rxbuf_we,
    input  logic [31:0]         udp_rxbuf_wdata,
    input  logic                app_tx_wr_en,
    input  logic [AW-1:0]       app_tx_wr_addr,
    input  logic [31:0]         app_tx_wr_data,
    input  logic                app_tx_send,
    input  logic [PERIOD_W-1:0] app_tx_period,
    output logic                app_tx_done,
    output logic [15:0]         app_tx_overrun,
    output logic                app_rx_valid,
    output logic [15:0]         app_rx_len,
    output logic                app_rx_trunc,
    input  logic [AW-1:0]       app_rx_rd_addr,
    output logic [31:0]         app_rx_rd_data,
    input  logic                app_rx_ack,
    output logic [15:0]         app_rx_cnt,
    output logic [15:0]         app_tx_cnt
);

    // Largest payload that fits behind the two header words of a bank.
    localparam logic [31:0] RX_CAP = 32'((2**AW - 2) * 4);

    tx_state_t           tx_state_q, tx_state_d;
    rx_state_t           rx_state_q, rx_state_d;
    logic                bank_sel_q, bank_sel_d;
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic                tx_rel_q, tx_rel_d;
    logic                tx_done_q, tx_done_d;
    logic [15:0]         tx_cnt_q, tx_cnt_d;
    logic [15:0]         overrun_q, overrun_d;
    logic                rx_grant_q;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_trunc_q, rx_trunc_d;
    logic                rx_rel_q, rx_rel_d;
    logic [15:0]         rx_len_q, rx_len_d;
    logic [15:0]         rx_cnt_q, rx_cnt_d;
    logic                launch;
    logic                timer_fire;
    logic                send_req;
    logic [31:0]         rx_mem_q [2**AW];
    logic [15:0]         udp_len;
    logic [15:0]         pay_len;
    logic                unused_ce;

    assign unused_ce = udp_txbuf_ce ^ udp_rxbuf_ce;

    // Core reads the active bank while the app fills the other one.
    udp_app_tx_bank #(.AW(AW)) u_tx_bank (
        .clk     (clk),
        .wr_en   (app_tx_wr_en),
        .wr_bank (~bank_sel_q),
        .wr_addr (app_tx_wr_addr),
        .wr_data (app_tx_wr_data),
        .rd_bank (bank_sel_q),
        .rd_addr (udp_txbuf_addr),
        .rd_data (udp_txbuf_rdata)
    );

    // Free-running period timer; a zero period holds it cleared.
    always_comb begin
        timer_d    = '0;
        timer_fire = 1'b0;
        if (app_tx_period != '0) begin
            if (timer_q >= app_tx_period - PERIOD_W'(1)) begin
                timer_fire = 1'b1;
            end else begin
                timer_d = timer_q + PERIOD_W'(1);
            end
        end
    end

    assign send_req = app_tx_send | timer_fire;

    // Merge send requests into one pending flag; a launch consumes it first.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (launch) begin
            pending_d = send_req;
        end else if (send_req) begin
            pending_d = 1'b1;
            if (pending_q && (overrun_q != 16'hffff)) begin
                overrun_d = overrun_q + 16'd1;
            end
        end
    end

    // TX handshake: swap banks and hand off, then wait for the buffer to come back.
    always_comb begin
        tx_state_d = tx_state_q;
        bank_sel_d = bank_sel_q;
        tx_rel_d   = 1'b0;
        tx_done_d  = 1'b0;
        tx_cnt_d   = tx_cnt_q;
        launch     = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (pending_q && udp_txbuf_grant) begin
                    launch     = 1'b1;
                    bank_sel_d = ~bank_sel_q;
                    tx_rel_d   = 1'b1;
                    tx_cnt_d   = tx_cnt_q + 16'd1;
                    tx_state_d = T_WAITLO;
                end
            end
            T_WAITLO: if (!udp_txbuf_grant) tx_state_d = T_WAITHI;
            T_WAITHI: begin
                if (udp_txbuf_grant) begin
                    tx_done_d  = 1'b1;
                    tx_state_d = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    assign udp_len = rx_mem_q[AW'(RXW_LEN)][31:16];
    assign pay_len = (udp_len < 16'(UDP_HDR_LEN)) ? 16'd0 : udp_len - 16'(UDP_HDR_LEN);

    // RX handshake: latch the length on grant rise, hold, then release.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_valid_d = 1'b0;
        rx_rel_d   = 1'b0;
        rx_len_d   = rx_len_q;
        rx_trunc_d = rx_trunc_q;
        rx_cnt_d   = rx_cnt_q;
        case (rx_state_q)
            R_IDLE: begin
                if (udp_rxbuf_grant && !rx_grant_q) begin
                    rx_len_d   = pay_len;
                    rx_trunc_d = 32'(pay_len) > RX_CAP;
                    rx_valid_d = 1'b1;
                    rx_cnt_d   = rx_cnt_q + 16'd1;
                    rx_state_d = R_HOLD;
                end
            end
            R_HOLD: begin
                if (AUTO_REL || app_rx_ack) begin
                    rx_rel_d   = 1'b1;
                    rx_state_d = R_WAIT;
                end
            end
            R_WAIT: if (!udp_rxbuf_grant) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
            bank_sel_q <= 1'b0;
            pending_q  <= 1'b0;
            timer_q    <= '0;
            tx_rel_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_cnt_q   <= '0;
            overrun_q  <= '0;
            rx_grant_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_trunc_q <= 1'b0;
            rx_rel_q   <= 1'b0;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            bank_sel_q <= bank_sel_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            tx_rel_q   <= tx_rel_d;
            tx_done_q  <= tx_done_d;
            tx_cnt_q   <= tx_cnt_d;
            overrun_q  <= overrun_d;
            rx_grant_q <= udp_rxbuf_grant;
            rx_valid_q <= rx_valid_d;
            rx_trunc_q <= rx_trunc_d;
            rx_rel_q   <= rx_rel_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    // RX packet store written by the core; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (udp_rxbuf_we) begin
            rx_mem_q[udp_rxbuf_addr] <= udp_rxbuf_wdata;
        end
    end

    assign app_rx_rd_data = rx_mem_q[app_rx_rd_addr];
    assign udp_txbuf_rel  = tx_rel_q;
    assign udp_rxbuf_rel  = rx_rel_q;
    assign app_tx_done    = tx_done_q;
    assign app_tx_overrun = overrun_q;
    assign app_tx_cnt     = tx_cnt_q;
    assign app_rx_valid   = rx_valid_q;
    assign app_rx_len     = rx_len_q;
    assign app_rx_trunc   = rx_trunc_q;
    assign app_rx_cnt     = rx_cnt_q;

endmodule

// File: tb/tb_udp_app_buf.sv
// tb/tb_udp_app_buf.sv - Self-checking bench for udp_app_buf
module tb_udp_app_buf;

    localparam int AW  = 6;
    localparam int PW  = 28;
    localparam int CAP = (2**AW - 2) * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tx_grant, tx_ce, rx_grant, rx_ce, rx_we, wr_en, send, rx_ack;
    logic [AW-1:0] tx_addr, rx_addr, wr_addr, rx_rd_addr;
    logic [31:0]   rx_wdata, wr_data;
    logic [PW-1:0] period;

    logic          tx_rel, rx_rel, tx_done, rx_valid, rx_trunc;
    logic [31:0]   tx_rdata, rx_rd_data;
    logic [15:0]   overrun, rx_len, rx_cnt, tx_cnt;

    logic          a_tx_rel, a_rx_rel, a_tx_done, a_rx_valid, a_rx_trunc;
    logic [31:0]   a_tx_rdata, a_rx_rd_data;
    logic [15:0]   a_overrun, a_rx_len, a_rx_cnt, a_tx_cnt;

    udp_app_buf #(.AW(AW), .PERIOD_W(PW), .AUTO_REL(1'b0)) dut (
        .clk(clk), .rst(rst),
        .udp_txbuf_grant(tx_grant), .udp_txbuf_rel(tx_rel), .udp_txbuf_addr(tx_addr),
        .udp_txbuf_ce(tx_ce), .udp_txbuf_rdata(tx_rdata),
        .udp_rxbuf_grant(rx_grant), .udp_rxbuf_rel(rx_rel), .udp_rxbuf_addr(rx_addr),
        .udp_rxbuf_ce(rx_ce), .udp_rxbuf_we(rx_we), .udp_rxbuf_wdata(rx_wdata),
        .app_tx_wr_en(wr_en), .app_tx_wr_addr(wr_addr), .app_tx_wr_data(wr_data),
        .app_tx_send(send), .app_tx_period(period), .app_tx_done(tx_done),
        .app_tx_overrun(overrun), .app_rx_valid(rx_valid), .app_rx_len(rx_len),
        .app_rx_trunc(rx_trunc), .app_rx_rd_addr(rx_rd_addr), .app_rx_rd_data(rx_rd_data),
        .app_rx_ack(rx_ack), .app_rx_cnt(rx_cnt), .app_tx_cnt(tx_cnt)
    );

    udp_app_buf #(.AW(AW), .PERIOD_W(PW), .AUTO_REL(1'b1)) dut_ar (
        .clk(clk), .rst(rst),
        .udp_txbuf_grant(tx_grant), .udp_txbuf_rel(a_tx_rel), .udp_txbuf_addr(tx_addr),
        .udp_txbuf_ce(tx_ce), .udp_txbuf_rdata(a_tx_rdata),
        .udp_rxbuf_grant(rx_grant), .udp_rxbuf_rel(a_rx_rel), .udp_rxbuf_addr(rx_addr),
        .udp_rxbuf_ce(rx_ce), .udp_rxbuf_we(rx_we), .udp_rxbuf_wdata(rx_wdata),
        .app_tx_wr_en(wr_en), .app_tx_wr_addr(wr_addr), .app_tx_wr_data(wr_data),
        .app_tx_send(send), .app_tx_period(period), .app_tx_done(a_tx_done),
        .app_tx_overrun(a_overrun), .app_rx_valid(a_rx_valid), .app_rx_len(a_rx_len),
        .app_rx_trunc(a_rx_trunc), .app_rx_rd_addr(rx_rd_addr), .app_rx_rd_data(a_rx_rd_data),
        .app_rx_ack(1'b0), .app_rx_cnt(a_rx_cnt), .app_tx_cnt(a_tx_cnt)
    );

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          rel_times[$];
    logic [31:0] exp_tx [2**AW];
    logic [31:0] exp_rx [2**AW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Behaves like the core: after each TX release, drop grant for three cycles, then return it.
    task automatic run_core(input int n);
        int lo = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_rel) begin
                rel_times.push_back(cyc);
                lo = 3;
            end
            if (lo > 0) begin
                tx_grant = 1'b0;
                lo--;
            end else begin
                tx_grant = 1'b1;
            end
        end
    endtask

    initial begin
        int          exp_tx_cnt;
        int          n_exp;
        int          ulen;
        int          elen;
        logic        etr;
        int          rx_lens[7];
        int          ra;
        logic        rel_seen;
        logic [31:0] old_word;

        rst = 1'b1; tx_grant = 0; tx_ce = 0; rx_grant = 0; rx_ce = 0; rx_we = 0;
        wr_en = 0; send = 0; rx_ack = 0; tx_addr = '0; rx_addr = '0; wr_addr = '0;
        rx_rd_addr = '0; rx_wdata = '0; wr_data = '0; period = '0;
        exp_tx_cnt = 0;
        tick(); tick();
        chk("rst_tx_rel", {31'b0, tx_rel}, 0);
        chk("rst_rx_rel", {31'b0, rx_rel}, 0);
        chk("rst_pulses", {28'b0, tx_done, rx_valid, rx_trunc, a_tx_rel}, 0);
        chk("rst_counts", {tx_cnt, rx_cnt}, 0);
        chk("rst_len_ovr", {rx_len, overrun}, 0);
        chk("rst_auto", {a_tx_done, a_rx_valid, a_rx_trunc, a_rx_rel, 28'b0}, 0);
        rst = 1'b0;
        tick();

        // TX one-shot
        tx_grant = 1'b1;
        exp_tx[0] = 32'h0a01a8c0;
        exp_tx[1] = 32'h045704d2;
        exp_tx[2] = 32'd15;
        for (int w = 3; w < 7; w++) exp_tx[w] = $urandom;
        for (int w = 0; w < 7; w++) begin
            wr_en = 1'b1; wr_addr = AW'(w); wr_data = exp_tx[w];
            tick();
        end
        wr_en = 1'b0;
        send = 1'b1;
        tick();
        send = 1'b0;
        chk("oneshot_rel_early", {31'b0, tx_rel}, 0);
        tick();
        chk("oneshot_rel", {31'b0, tx_rel}, 1);
        exp_tx_cnt++;
        chk("oneshot_cnt", {16'b0, tx_cnt}, exp_tx_cnt);
        for (int w = 0; w < 7; w++) begin
            tx_addr = AW'(w);
            #1;
            chk($sformatf("oneshot_rd%0d", w), tx_rdata, exp_tx[w]);
        end
        wr_en = 1'b1; wr_addr = '0; wr_data = ~exp_tx[0];
        tick();
        wr_en = 1'b0; tx_addr = '0;
        #1;
        chk("shadow_isolated", tx_rdata, exp_tx[0]);
        tx_grant = 1'b0;
        tick(); tick();
        tx_grant = 1'b1;
        tick();
        chk("oneshot_done", {31'b0, tx_done}, 1);
        tick();
        chk("done_pulse_end", {31'b0, tx_done}, 0);

        // Periodic send
        rel_times.delete();
        period = PW'(100);
        run_core(450);
        n_exp = (450 - 1) / 100;
        chk("periodic_count", rel_times.size(), n_exp);
        for (int i = 1; i < rel_times.size(); i++)
            chk($sformatf("periodic_gap%0d", i), rel_times[i] - rel_times[i-1], 100);
        exp_tx_cnt += n_exp;
        period = '0;
        run_core(300);
        chk("period_off", rel_times.size(), n_exp);
        chk("periodic_no_ovr", {16'b0, overrun}, 0);

        // Overrun with grant held low
        tx_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send = 1'b1; tick();
            send = 1'b0; tick();
        end
        chk("overrun_cnt", {16'b0, overrun}, 2);
        rel_times.delete();
        run_core(20);
        chk("overrun_one_rel", rel_times.size(), 1);
        exp_tx_cnt++;

        // Request landing in the cycle pending clears
        send = 1'b1;
        tick(); tick();
        chk("clear_cycle_rel", {31'b0, tx_rel}, 1);
        send = 1'b0; tx_grant = 1'b0;
        rel_times.delete();
        run_core(30);
        chk("clear_cycle_second", rel_times.size(), 1);
        chk("clear_cycle_no_ovr", {16'b0, overrun}, 2);
        exp_tx_cnt += 2;
        chk("tx_cnt_total", {16'b0, tx_cnt}, exp_tx_cnt);

        // RX packets: directed corners then random
        rx_lens = '{'h17, 'h4, 'h200, 8, 256, 257, 0};
        rx_lens[6] = $urandom_range(0, 16'hffff);
        for (int k = 0; k < 7; k++) begin
            ulen = rx_lens[k];
            exp_rx[1] = {ulen[15:0], 16'($urandom)};
            for (int w = 2; w < 6; w++) exp_rx[w] = $urandom;
            for (int w = 1; w < 6; w++) begin
                rx_we = 1'b1; rx_addr = AW'(w); rx_wdata = exp_rx[w];
                tick();
            end
            rx_we = 1'b0;
            elen = (ulen < 8) ? 0 : ulen - 8;
            etr = (elen > CAP);
            rx_grant = 1'b1;
            tick();
            chk($sformatf("rx%0d_valid", k), {30'b0, rx_valid, a_rx_valid}, 3);
            chk($sformatf("rx%0d_len", k), {16'b0, rx_len}, elen);
            chk($sformatf("rx%0d_trunc", k), {31'b0, rx_trunc}, {31'b0, etr});
            chk($sformatf("rx%0d_auto_len", k), {15'b0, a_rx_trunc, a_rx_len}, {15'b0, etr, 16'(elen)});
            chk($sformatf("rx%0d_cnt", k), {rx_cnt, a_rx_cnt}, {16'(k + 1), 16'(k + 1)});
            tick();
            chk($sformatf("rx%0d_auto_rel", k), {30'b0, a_rx_rel, rx_rel}, 2);
            chk($sformatf("rx%0d_valid_end", k), {31'b0, rx_valid}, 0);
            ra = 2 + $urandom_range(0, 3);
            rx_rd_addr = AW'(ra);
            #1;
            chk($sformatf("rx%0d_rd", k), rx_rd_data, exp_rx[ra]);
            chk($sformatf("rx%0d_rd_auto", k), a_rx_rd_data, exp_rx[ra]);
            if (k == 0) begin
                old_word = exp_rx[3];
                exp_rx[3] = $urandom;
                rx_we = 1'b1; rx_addr = AW'(3); rx_wdata = exp_rx[3]; rx_rd_addr = AW'(3);
                #1;
                chk("rx_same_addr_old", rx_rd_data, old_word);
                tick();
                rx_we = 1'b0;
                chk("rx_same_addr_new", rx_rd_data, exp_rx[3]);
                chk("rx_hold_no_rel", {31'b0, rx_rel}, 0);
            end
            rx_ack = 1'b1;
            tick();
            rx_ack = 1'b0;
            chk($sformatf("rx%0d_ack_rel", k), {31'b0, rx_rel}, 1);
            rx_grant = 1'b0;
            tick(); tick();
        end

        // Asynchronous reset with TX in T_WAITLO (pending set) and RX in R_HOLD
        tx_grant = 1'b1;
        send = 1'b1; tick();
        send = 1'b0; tick();
        chk("pre_rst_rel", {31'b0, tx_rel}, 1);
        send = 1'b1; tick();
        send = 1'b0;
        rx_we = 1'b1; rx_addr = AW'(1); rx_wdata = {16'd40, 16'h0};
        tick();
        rx_we = 1'b0; rx_grant = 1'b1;
        tick();
        chk("pre_rst_valid", {31'b0, rx_valid}, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_counts", {tx_cnt, rx_cnt}, 0);
        chk("async_rst_rx", {15'b0, rx_valid, rx_len}, 0);
        chk("async_rst_ovr", {16'b0, overrun}, 0);
        rx_grant = 1'b0;
        tick(); tick();
        chk("rst_no_rel", {29'b0, tx_rel, rx_rel, a_rx_rel}, 0);
        rst = 1'b0;
        rel_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rel_seen = rel_seen | tx_rel | rx_rel | a_rx_rel | rx_valid;
        end
        chk("post_rst_quiet", {31'b0, rel_seen}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
